// File: rtl/obi_sram_responder.sv
// OBI responder in front of one single-port SRAM bank. In-range accesses go to the SRAM.
// Out-of-range accesses are granted, answered locally with an error pattern, and counted.
module obi_sram_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          NUM_WORDS   = 8192,
  parameter int          MEM_LATENCY = 1,
  parameter logic [31:0] ERR_RDATA   = 32'hBADA_CCE5,
  parameter int          AW          = $clog2(NUM_WORDS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_i,
  input  logic [31:0]   addr_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic          gnt_o,
  output logic          rvalid_o,
  output logic [31:0]   rdata_o,
  output logic          sram_req_o,
  input  logic          sram_gnt_i,
  output logic [AW-1:0] sram_addr_o,
  output logic          sram_we_o,
  output logic [3:0]    sram_be_o,
  output logic [31:0]   sram_wdata_o,
  input  logic [31:0]   sram_rdata_i,
  output logic [15:0]   err_count_o
);

  localparam logic [32:0] SPAN = 33'(NUM_WORDS) << 2;
  localparam int          LAST = MEM_LATENCY - 1;

  logic [31:0] offset;
  logic        in_range;
  logic        accept;

  // Handshake: a request is accepted in every cycle where req_i && gnt_o; the master keeps
  // the request stable while gnt_o is low. Exactly one rvalid_o pulse follows each accept,
  // MEM_LATENCY cycles later, in accept order, with no backpressure on the response side.
  assign offset   = addr_i - BASE_ADDR;
  assign in_range = (addr_i >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign gnt_o    = req_i & (~in_range | sram_gnt_i);
  assign accept   = req_i & gnt_o;

  assign sram_req_o   = req_i & in_range;
  assign sram_addr_o  = offset[AW+1:2];
  assign sram_we_o    = we_i;
  assign sram_be_o    = be_i;
  assign sram_wdata_o = wdata_i;

  // Tracking pipeline mirrors the SRAM read latency, one stage per cycle.
  logic [MEM_LATENCY-1:0] valid_q, we_q, err_q;
  logic                   valid_d, we_d, err_d;

  assign valid_d = accept;
  assign we_d    = we_i;
  assign err_d   = ~in_range;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      we_q    <= '0;
      err_q   <= '0;
    end else begin
      valid_q[0] <= valid_d;
      we_q[0]    <= we_d;
      err_q[0]   <= err_d;
      for (int k = 1; k < MEM_LATENCY; k++) begin
        valid_q[k] <= valid_q[k-1];
        we_q[k]    <= we_q[k-1];
        err_q[k]   <= err_q[k-1];
      end
    end
  end

  assign rvalid_o = valid_q[LAST];

  always_comb begin
    rdata_o = 32'h0;
    if (valid_q[LAST] && !we_q[LAST]) begin
      rdata_o = err_q[LAST] ? ERR_RDATA : sram_rdata_i;
    end
  end

  logic [15:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (accept && !in_range && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_count_q <= 16'h0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count_o = err_count_q;

endmodule

// File: tb/tb_obi_sram_responder.sv
// Bench for obi_sram_responder: behavioural SRAM, reference memory plus expected-response
// queue, boundary vector table, directed multi-cycle sequences and randomized traffic.
module tb_obi_sram_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          NW   = 64;
  localparam int          L    = 3;
  localparam logic [31:0] ERR  = 32'hBADA_CCE5;
  localparam int          AW   = $clog2(NW);

  logic          clk = 1'b0;
  logic          rst, req, we, sram_gnt;
  logic [31:0]   addr, wdata;
  logic [3:0]    be;
  logic          gnt, rvalid, sram_req, sram_we;
  logic [31:0]   rdata, sram_wdata, sram_rdata;
  logic [AW-1:0] sram_addr;
  logic [3:0]    sram_be;
  logic [15:0]   err_count;

  obi_sram_responder #(
    .BASE_ADDR(BASE), .NUM_WORDS(NW), .MEM_LATENCY(L), .ERR_RDATA(ERR)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .sram_req_o(sram_req), .sram_gnt_i(sram_gnt), .sram_addr_o(sram_addr),
    .sram_we_o(sram_we), .sram_be_o(sram_be), .sram_wdata_o(sram_wdata),
    .sram_rdata_i(sram_rdata), .err_count_o(err_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural SRAM (environment) ----------------
  logic        sram_clear;
  logic [31:0] sram_mem [NW];
  logic [31:0] rd_pipe [L];

  always @(posedge clk) begin
    if (sram_clear) begin
      for (int i = 0; i < NW; i++) sram_mem[i] <= 32'h0;
    end else if (sram_req && sram_gnt) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
      rd_pipe[0] <= sram_mem[sram_addr];
    end
    for (int k = 1; k < L; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign sram_rdata = rd_pipe[L-1];

  // ---------------- reference model and scoreboard ----------------
  logic [31:0] ref_mem [NW];
  logic [31:0] exp_q [$];
  int          due_q [$];
  int          model_err;
  int          cyc;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rsp;
  logic        smp_gnt, smp_sreq;
  logic [31:0] smp_saddr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic model_in_range(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (off >= 0) && (off < longint'(NW) * 4);
  endfunction

  function automatic int model_word(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  // One bus cycle: drive, sample mid-cycle against the model, then advance the model.
  task automatic cycle(input logic r, input logic [31:0] a, input logic w,
                       input logic [3:0] b, input logic [31:0] d,
                       input logic sg, input logic rs);
    logic inr, exp_g, exp_rv;
    logic [31:0] exp_rd;
    int idx;
    rst = rs; req = r; addr = a; we = w; be = b; wdata = d; sram_gnt = sg;
    #4;
    inr   = model_in_range(a);
    idx   = inr ? model_word(a) : 0;
    exp_g = r && (!inr || sg);
    smp_gnt = gnt; smp_sreq = sram_req; smp_saddr = 32'(sram_addr);
    chk("gnt", 32'(gnt), 32'(exp_g));
    chk("sram_req", 32'(sram_req), 32'(r && inr));
    if (r && inr) begin
      chk("sram_addr", 32'(sram_addr), 32'(idx));
      chk("sram_we", 32'(sram_we), 32'(w));
      chk("sram_be", 32'(sram_be), 32'(b));
      chk("sram_wdata", sram_wdata, d);
    end
    exp_rv = (due_q.size() > 0) && (due_q[0] == cyc);
    exp_rd = exp_rv ? exp_q[0] : 32'h0;
    chk("rvalid", 32'(rvalid), 32'(exp_rv));
    chk("rdata", rdata, exp_rd);
    if (rvalid) last_rsp = rdata;
    if (exp_rv) begin
      void'(due_q.pop_front());
      void'(exp_q.pop_front());
    end
    chk("err_count", 32'(err_count), 32'(model_err));
    if (rs) begin
      exp_q.delete();
      due_q.delete();
      model_err = 0;
    end else if (exp_g) begin
      if (!inr) begin
        if (model_err < 65535) model_err++;
        exp_q.push_back(w ? 32'h0 : ERR);
      end else if (w) begin
        for (int k = 0; k < 4; k++)
          if (b[k]) ref_mem[idx][8*k +: 8] = d[8*k +: 8];
        exp_q.push_back(32'h0);
      end else begin
        exp_q.push_back(ref_mem[idx]);
      end
      due_q.push_back(cyc + L);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1);
  endtask

  // ---------------- boundary vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic        sg;
    logic        exp_gnt;
    logic        exp_sreq;
    logic [31:0] exp_word;
  } vec_t;

  vec_t tbl [9];

  // ---------------- driver ----------------
  logic        pend;
  logic        r_req, r_we, r_sg;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_be;

  initial begin
    rst = 1'b1; req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0; sram_gnt = 1'b1;
    sram_clear = 1'b1; model_err = 0; cyc = 0; last_rsp = '0;
    for (int i = 0; i < NW; i++) ref_mem[i] = 32'h0;

    tbl[0] = '{32'h0000_1000, 1'b1, 1'b1, 1'b1, 32'd0};
    tbl[1] = '{32'h0000_1003, 1'b1, 1'b1, 1'b1, 32'd0};
    tbl[2] = '{32'h0000_10FC, 1'b1, 1'b1, 1'b1, 32'd63};
    tbl[3] = '{32'h0000_1100, 1'b1, 1'b1, 1'b0, 32'd0};
    tbl[4] = '{32'h0000_0FFC, 1'b1, 1'b1, 1'b0, 32'd0};
    tbl[5] = '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'd0};
    tbl[6] = '{32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 32'd0};
    tbl[7] = '{32'h1000_1000, 1'b1, 1'b1, 1'b0, 32'd0};
    tbl[8] = '{32'h0000_1010, 1'b0, 1'b0, 1'b1, 32'd4};

    @(posedge clk);
    #1;
    sram_clear = 1'b0;
    do_reset(2);

    // Boundary addresses: grant and SRAM request decode.
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, tbl[i].addr, 1'b0, 4'hF, 32'h0, tbl[i].sg, 1'b0);
      chk("tbl_gnt", 32'(smp_gnt), 32'(tbl[i].exp_gnt));
      chk("tbl_sreq", 32'(smp_sreq), 32'(tbl[i].exp_sreq));
      if (tbl[i].exp_sreq) chk("tbl_word", smp_saddr, tbl[i].exp_word);
    end
    idle(L + 1);

    // Write then read back-to-back.
    cycle(1'b1, BASE + 32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b1, 1'b0);
    cycle(1'b1, BASE + 32'h10, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0);
    idle(L + 1);
    chk("wr_rd_data", last_rsp, 32'hDEAD_BEEF);

    // Preload words 0..3 then four back-to-back reads.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, BASE + 32'(4 * i), 1'b1, 4'hF, 32'(8'h11 * (i + 1)), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      cycle(1'b1, BASE + 32'(4 * i), 1'b0, 4'hF, 32'h0, 1'b1, 1'b0);
    idle(L + 1);
    chk("b2b_last", last_rsp, 32'h44);

    // Out-of-range read and write after a fresh reset.
    do_reset(1);
    cycle(1'b1, BASE + 32'(NW * 4), 1'b0, 4'hF, 32'h0, 1'b1, 1'b0);
    idle(L + 1);
    chk("oor_rd_data", last_rsp, ERR);
    cycle(1'b1, BASE - 32'h4, 1'b1, 4'hF, 32'h1234_5678, 1'b1, 1'b0);
    idle(L + 1);
    chk("oor_wr_data", last_rsp, 32'h0);
    chk("oor_count", 32'(err_count), 32'd2);

    // SRAM arbiter withholds grant for five cycles.
    for (int i = 0; i < 5; i++) cycle(1'b1, BASE + 32'h14, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, BASE + 32'h14, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0);
    idle(L + 1);

    // Partial write into a zero word.
    cycle(1'b1, BASE + 32'h40, 1'b1, 4'b0010, 32'hAABB_CCDD, 1'b1, 1'b0);
    cycle(1'b1, BASE + 32'h40, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0);
    idle(L + 1);
    chk("partial_wr", last_rsp, 32'h0000_CC00);

    // Reset with two reads in flight: their responses must vanish.
    cycle(1'b1, BASE + 32'h0, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, BASE + 32'h4, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0);
    do_reset(1);
    idle(L + 2);
    chk("rst_err_count", 32'(err_count), 32'd0);
    last_rsp = '0;
    cycle(1'b1, BASE + 32'h0, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0);
    idle(L + 1);
    chk("post_rst_read", last_rsp, 32'h11);

    // Randomized traffic; a stalled in-range request is held stable until granted.
    pend = 1'b0;
    r_req = 1'b0; r_we = 1'b0; r_addr = '0; r_wdata = '0; r_be = '0;
    for (int n = 0; n < 500; n++) begin
      if (!pend) begin
        r_req = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 7))
          0:       r_addr = BASE - 32'h4;
          1:       r_addr = BASE + 32'(NW * 4);
          2:       r_addr = $urandom;
          default: r_addr = BASE + 32'($urandom_range(0, NW * 4 - 1));
        endcase
        r_we    = 1'($urandom_range(0, 1));
        r_be    = 4'($urandom_range(0, 15));
        r_wdata = $urandom;
      end
      r_sg = ($urandom_range(0, 3) != 0);
      cycle(r_req, r_addr, r_we, r_be, r_wdata, r_sg, 1'b0);
      pend = r_req && model_in_range(r_addr) && !r_sg;
    end
    idle(L + 2);
    chk("drain", 32'(due_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
